contador_lotes: RTL and testbench

CONTADOR_LOTES -- requirements
Module: contador_lotes

---
 rtl/contador_lotes_if.sv | 28 ++
 rtl/contador_lotes.sv | 142 ++++++++++++++
 tb/tb_contador_lotes.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/contador_lotes_if.sv
// Bottle/lot counter bus: operator and sensor inputs plus the count outputs.
// The master drives the inputs; the slave is the counter itself.
interface contador_lotes_if #(
   parameter int LARG_LOTES = 7
);
   logic                  incrementar;
   logic                  estornar;
   logic                  reset_manual;
   logic                  habilitar;
   logic [7:0]            unidades_valor;
   logic [LARG_LOTES-1:0] lotes_valor;
   logic [15:0]           contador_total;
   logic                  pulso_lote;
   logic                  pulso_cheio;
   logic                  cheio;

   modport master (
      output incrementar, estornar, reset_manual, habilitar,
      input  unidades_valor, lotes_valor, contador_total,
      input  pulso_lote, pulso_cheio, cheio
   );

   modport slave (
      input  incrementar, estornar, reset_manual, habilitar,
      output unidades_valor, lotes_valor, contador_total,
      output pulso_lote, pulso_cheio, cheio
   );
endinterface

// File: rtl/contador_lotes.sv
// Approved-bottle counter: groups bottles into lots, counts lots and keeps a
// running total; a reject rise removes one bottle from the open lot.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_CONTA  | counting; sensor edges update the counters
// ST_CHEIO  | lot count saturated at MAX_LOTES; edges ignored until a clear
module contador_lotes #(
   parameter int UNIDADES_POR_LOTE = 12,
   parameter int MAX_LOTES         = 10,
   parameter int LARG_LOTES        = 7,
   parameter int MODO_AUTO_RESET   = 1
) (
   input logic             clk,
   input logic             reset,
   contador_lotes_if.slave bus
);

   localparam logic [7:0]            UNI_ULTIMA = 8'(UNIDADES_POR_LOTE - 1);
   localparam logic [LARG_LOTES-1:0] LOTE_ULTIMO = LARG_LOTES'(MAX_LOTES - 1);
   localparam logic [LARG_LOTES-1:0] LOTE_MAX    = LARG_LOTES'(MAX_LOTES);

   typedef enum logic {ST_CONTA = 1'b0, ST_CHEIO = 1'b1} estado_t;

   estado_t               estado;
   estado_t               estado_prox;

   logic                  prev_inc;
   logic                  prev_est;
   logic                  ev_inc;
   logic                  ev_est;

   logic [7:0]            unidades;
   logic [LARG_LOTES-1:0] lotes;
   logic [15:0]           total;
   logic                  pulso_lote_r;
   logic                  pulso_cheio_r;

   logic                  conta_ok;
   logic                  inc_ok;
   logic                  est_ok;
   logic                  fecha_lote;
   logic                  atinge_max;
   logic                  cheio;

   assign ev_inc = bus.incrementar & ~prev_inc;
   assign ev_est = bus.estornar & ~prev_est;

   // Simultaneous rises cancel; a reject on an empty lot never reopens one.
   assign conta_ok   = bus.habilitar & ~bus.reset_manual & (estado == ST_CONTA);
   assign inc_ok     = conta_ok & ev_inc & ~ev_est;
   assign est_ok     = conta_ok & ev_est & ~ev_inc & (unidades != 8'd0);
   assign fecha_lote = inc_ok & (unidades == UNI_ULTIMA);
   assign atinge_max = fecha_lote & (lotes == LOTE_ULTIMO);

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_inc <= 1'b0;
         prev_est <= 1'b0;
      end else begin
         prev_inc <= bus.incrementar;
         prev_est <= bus.estornar;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado <= ST_CONTA;
      end else begin
         estado <= estado_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         ST_CONTA: begin
            if (atinge_max && (MODO_AUTO_RESET == 0)) begin
               estado_prox = ST_CHEIO;
            end
         end
         ST_CHEIO: begin
            if (bus.reset_manual) begin
               estado_prox = ST_CONTA;
            end
         end
         default: estado_prox = ST_CONTA;
      endcase
   end

   always_comb begin
      cheio = 1'b0;
      if (estado == ST_CHEIO) begin
         cheio = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         unidades      <= 8'd0;
         lotes         <= '0;
         total         <= 16'd0;
         pulso_lote_r  <= 1'b0;
         pulso_cheio_r <= 1'b0;
      end else if (bus.reset_manual) begin
         unidades      <= 8'd0;
         lotes         <= '0;
         total         <= 16'd0;
         pulso_lote_r  <= 1'b0;
         pulso_cheio_r <= 1'b0;
      end else begin
         pulso_lote_r  <= fecha_lote;
         pulso_cheio_r <= atinge_max;
         if (inc_ok) begin
            total <= total + 16'd1;
            if (fecha_lote) begin
               unidades <= 8'd0;
               if (!atinge_max) begin
                  lotes <= lotes + 1'b1;
               end else if (MODO_AUTO_RESET != 0) begin
                  lotes <= '0;
               end else begin
                  lotes <= LOTE_MAX;
               end
            end else begin
               unidades <= unidades + 8'd1;
            end
         end else if (est_ok) begin
            unidades <= unidades - 8'd1;
            total    <= total - 16'd1;
         end
      end
   end

   assign bus.unidades_valor = unidades;
   assign bus.lotes_valor    = lotes;
   assign bus.contador_total = total;
   assign bus.pulso_lote     = pulso_lote_r;
   assign bus.pulso_cheio    = pulso_cheio_r;
   assign bus.cheio          = cheio;

endmodule

// File: tb/tb_contador_lotes.sv
// Bench for contador_lotes: a wrapping default instance and a small saturating
// instance share one stimulus stream and are compared every cycle to a model.
module tb_contador_lotes;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inc = 1'b0;
   logic est = 1'b0;
   logic rm  = 1'b0;
   logic hab = 1'b1;

   int n_chk = 0;
   int n_err = 0;
   int n_cheio_pulsos = 0;

   always #10 clk = ~clk;

   contador_lotes_if #(.LARG_LOTES(7)) b0 ();
   contador_lotes_if #(.LARG_LOTES(7)) b1 ();

   assign b0.incrementar  = inc;
   assign b0.estornar     = est;
   assign b0.reset_manual = rm;
   assign b0.habilitar    = hab;
   assign b1.incrementar  = inc;
   assign b1.estornar     = est;
   assign b1.reset_manual = rm;
   assign b1.habilitar    = hab;

   contador_lotes #(
      .UNIDADES_POR_LOTE(12), .MAX_LOTES(10), .LARG_LOTES(7), .MODO_AUTO_RESET(1)
   ) dut0 (.clk(clk), .reset(rst), .bus(b0.slave));

   contador_lotes #(
      .UNIDADES_POR_LOTE(3), .MAX_LOTES(2), .LARG_LOTES(7), .MODO_AUTO_RESET(0)
   ) dut1 (.clk(clk), .reset(rst), .bus(b1.slave));

   // Reference model: per-instance bottle bookkeeping in plain integers.
   int cfg_uni[2]  = '{12, 3};
   int cfg_max[2]  = '{10, 2};
   int cfg_auto[2] = '{1, 0};

   int m_uni[2], m_lotes[2], m_total[2], m_pl[2], m_pc[2], m_cheio[2];
   int m_prev_inc = 0;
   int m_prev_est = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelo();
      bit sobe_inc, sobe_est;
      sobe_inc = (inc === 1'b1) && (m_prev_inc == 0);
      sobe_est = (est === 1'b1) && (m_prev_est == 0);
      for (int k = 0; k < 2; k++) begin
         m_pl[k] = 0;
         m_pc[k] = 0;
         if (rst || rm) begin
            m_uni[k] = 0; m_lotes[k] = 0; m_total[k] = 0; m_cheio[k] = 0;
         end else if (hab && !m_cheio[k]) begin
            if (sobe_inc && !sobe_est) begin
               m_total[k] = (m_total[k] + 1) % 65536;
               m_uni[k]++;
               if (m_uni[k] == cfg_uni[k]) begin
                  m_uni[k] = 0;
                  m_pl[k] = 1;
                  m_lotes[k]++;
                  if (m_lotes[k] == cfg_max[k]) begin
                     m_pc[k] = 1;
                     if (cfg_auto[k] != 0) m_lotes[k] = 0;
                     else m_cheio[k] = 1;
                  end
               end
            end else if (sobe_est && !sobe_inc && m_uni[k] > 0) begin
               m_uni[k]--;
               m_total[k]--;
            end
         end
      end
      m_prev_inc = rst ? 0 : int'(inc);
      m_prev_est = rst ? 0 : int'(est);
   endtask

   task automatic ciclo();
      modelo();
      @(posedge clk);
      @(negedge clk);
      chk("uni0",   int'(b0.unidades_valor), m_uni[0]);
      chk("lotes0", int'(b0.lotes_valor),    m_lotes[0]);
      chk("total0", int'(b0.contador_total), m_total[0]);
      chk("plote0", int'(b0.pulso_lote),     m_pl[0]);
      chk("pcheio0",int'(b0.pulso_cheio),    m_pc[0]);
      chk("cheio0", int'(b0.cheio),          m_cheio[0]);
      chk("uni1",   int'(b1.unidades_valor), m_uni[1]);
      chk("lotes1", int'(b1.lotes_valor),    m_lotes[1]);
      chk("total1", int'(b1.contador_total), m_total[1]);
      chk("plote1", int'(b1.pulso_lote),     m_pl[1]);
      chk("pcheio1",int'(b1.pulso_cheio),    m_pc[1]);
      chk("cheio1", int'(b1.cheio),          m_cheio[1]);
      if (b0.pulso_lote === 1'b1 && b0.pulso_cheio === 1'b1) n_cheio_pulsos++;
   endtask

   task automatic pulsa_inc(input int n);
      for (int i = 0; i < n; i++) begin
         inc = 1'b1; ciclo();
         inc = 1'b0; ciclo();
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1; ciclo(); ciclo();
      rst = 1'b0; ciclo();
      chk("reset_total0", int'(b0.contador_total), 0);

      // Twelve bottles close exactly one lot
      pulsa_inc(12);
      chk("lote12_uni",   int'(b0.unidades_valor), 0);
      chk("lote12_lotes", int'(b0.lotes_valor),    1);
      chk("lote12_total", int'(b0.contador_total), 12);

      // 120 bottles wrap the lot count; saturating instance stops at 6
      n_cheio_pulsos = 0;
      pulsa_inc(108);
      chk("wrap_lotes",  int'(b0.lotes_valor),    0);
      chk("wrap_total",  int'(b0.contador_total), 120);
      chk("wrap_cheio",  int'(b0.cheio),          0);
      chk("wrap_pulsos", n_cheio_pulsos,          1);
      chk("sat_lotes",   int'(b1.lotes_valor),    2);
      chk("sat_cheio",   int'(b1.cheio),          1);
      chk("sat_total",   int'(b1.contador_total), 6);

      rm = 1'b1; ciclo(); rm = 1'b0; ciclo();
      chk("rm_total1", int'(b1.contador_total), 0);
      chk("rm_cheio1", int'(b1.cheio),          0);

      // Rejects: decrement, ignore at empty lot, cancel against a simultaneous rise
      pulsa_inc(5);
      est = 1'b1; ciclo(); est = 1'b0; ciclo();
      chk("estorno_uni", int'(b0.unidades_valor), 4);
      for (int i = 0; i < 5; i++) begin est = 1'b1; ciclo(); est = 1'b0; ciclo(); end
      chk("estorno_vazio", int'(b0.unidades_valor), 0);
      inc = 1'b1; est = 1'b1; ciclo(); inc = 1'b0; est = 1'b0; ciclo();

      // Held level counts once; a rise while disabled is lost
      inc = 1'b1;
      for (int i = 0; i < 100; i++) ciclo();
      inc = 1'b0; ciclo();
      hab = 1'b0; inc = 1'b1; ciclo(); ciclo();
      hab = 1'b1; ciclo(); ciclo(); inc = 1'b0; ciclo();

      // Clear on the same cycle as the closing rise
      rm = 1'b1; ciclo(); rm = 1'b0;
      pulsa_inc(11);
      rm = 1'b1; inc = 1'b1; ciclo(); rm = 1'b0; inc = 1'b0; ciclo();
      chk("rm_inc_plote", int'(b0.pulso_lote), 0);

      // Reset while saturated, and input held through reset release
      pulsa_inc(6);
      rst = 1'b1; inc = 1'b1; ciclo();
      rst = 1'b0; ciclo(); ciclo(); inc = 1'b0; ciclo();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         inc = 1'($urandom_range(0, 2) == 0) ? ~inc : inc;
         est = 1'($urandom_range(0, 5) == 0) ? ~est : est;
         rm  = 1'($urandom_range(0, 199) == 0);
         rst = 1'($urandom_range(0, 499) == 0);
         hab = 1'($urandom_range(0, 7) != 0);
         ciclo();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
